// File: rtl/i2s_audio_rx_pkg.sv
// Shared audio definitions: default sample width, receiver FSM encoding and
// the signed sample type handed to the FIR stage.
package i2s_audio_rx_pkg;

    localparam int unsigned SAMPLE_WIDTH_DEFAULT = 16;

    typedef logic signed [SAMPLE_WIDTH_DEFAULT-1:0] sample_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLeft  = 2'd1,
        StRight = 2'd2
    } rx_state_e;

endpackage

// File: rtl/i2s_audio_rx_sync_edge_det.sv
// Two-flop synchronizer for one asynchronous input, with a third flop for
// rise/fall detection on the synchronized value.
module i2s_audio_rx_sync_edge_det (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_sync = r_sync2;
    assign o_rise = r_sync2 & ~r_sync3;
    assign o_fall = ~r_sync2 & r_sync3;

endmodule

// File: rtl/i2s_audio_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdat on the system clock, captures
// MSB-first words per slot and commits one stereo frame per strobe.
module i2s_audio_rx
    import i2s_audio_rx_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
    parameter bit          MONO_MIX     = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_i2s_bclk,
    input  logic                           i_i2s_lrclk,
    input  logic                           i_i2s_sdat,
    output logic signed [SAMPLE_WIDTH-1:0] o_data,
    output logic signed [SAMPLE_WIDTH-1:0] o_data_l,
    output logic signed [SAMPLE_WIDTH-1:0] o_data_r,
    output logic                           o_sample_valid,
    output logic                           o_err_short,
    output logic                           o_locked
);

    localparam logic [5:0]              CNT_MAX  = 6'd63;
    localparam logic [5:0]              WIDTH6   = 6'(SAMPLE_WIDTH);
    localparam logic [SAMPLE_WIDTH-1:0] MSB_MASK = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    logic w_bclk_rise;
    logic w_lr;
    logic w_sd;
    logic w_unused_bclk_sync;
    logic w_unused_bclk_fall;
    logic w_unused_lr_rise;
    logic w_unused_lr_fall;
    logic w_unused_sd_rise;
    logic w_unused_sd_fall;

    i2s_audio_rx_sync_edge_det u_sync_bclk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_i2s_bclk),
        .o_sync  (w_unused_bclk_sync),
        .o_rise  (w_bclk_rise),
        .o_fall  (w_unused_bclk_fall)
    );

    i2s_audio_rx_sync_edge_det u_sync_lrclk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_i2s_lrclk),
        .o_sync  (w_lr),
        .o_rise  (w_unused_lr_rise),
        .o_fall  (w_unused_lr_fall)
    );

    i2s_audio_rx_sync_edge_det u_sync_sdat (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_i2s_sdat),
        .o_sync  (w_sd),
        .o_rise  (w_unused_sd_rise),
        .o_fall  (w_unused_sd_fall)
    );

    logic                    r_lr_prev;
    logic [5:0]              r_cnt;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic [SAMPLE_WIDTH-1:0] r_data;
    logic [SAMPLE_WIDTH-1:0] r_data_l;
    logic [SAMPLE_WIDTH-1:0] r_data_r;
    logic                    r_valid;
    logic                    r_err_short;
    logic                    r_locked;
    rx_state_e               r_state;
    rx_state_e               w_state_next;

    logic                    w_boundary;
    logic                    w_short;
    logic [SAMPLE_WIDTH-1:0] w_mask;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic [SAMPLE_WIDTH:0]   w_sum;
    logic [SAMPLE_WIDTH-1:0] w_mix;
    logic                    w_lock;
    logic                    w_latch_left;
    logic                    w_commit;

    assign w_boundary = w_bclk_rise & (w_lr ^ r_lr_prev);
    // The bit sampled at the boundary rise is the outgoing word's LSB (the
    // one-bit I2S delay), so it closes the old word and never enters the new one.
    assign w_short    = r_cnt < (WIDTH6 - 6'd1);
    // Bits are written left-justified; the mask falls off the end once
    // SAMPLE_WIDTH bits are in, so extra slot bits are dropped.
    assign w_mask     = MSB_MASK >> r_cnt;
    assign w_word     = w_sd ? (r_shift | w_mask) : r_shift;

    // Sign-extended sum; dropping bit 0 is the arithmetic shift right by one.
    assign w_sum = {r_left_hold[SAMPLE_WIDTH-1], r_left_hold} + {w_word[SAMPLE_WIDTH-1], w_word};
    assign w_mix = MONO_MIX ? SAMPLE_WIDTH'(w_sum >> 1) : r_left_hold;

    // Shift register, saturating bit counter and previous lrclk sample.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lr_prev <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
        end else if (w_bclk_rise) begin
            r_lr_prev <= w_lr;
            if (w_boundary) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else begin
                r_shift <= w_word;
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and frame control decode.
    always_comb begin
        w_state_next = r_state;
        w_lock       = 1'b0;
        w_latch_left = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_boundary && !w_lr) begin
                    w_state_next = StLeft;
                    w_lock       = 1'b1;
                end
            end
            StLeft: begin
                if (w_boundary) begin
                    w_state_next = StRight;
                    w_latch_left = 1'b1;
                end
            end
            StRight: begin
                if (w_boundary) begin
                    w_state_next = StLeft;
                    w_commit     = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Left holding register, committed outputs, strobes and lock flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_left_hold <= '0;
            r_data      <= '0;
            r_data_l    <= '0;
            r_data_r    <= '0;
            r_valid     <= 1'b0;
            r_err_short <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_valid     <= w_commit;
            r_err_short <= (w_latch_left | w_commit) & w_short;
            if (w_lock) begin
                r_locked <= 1'b1;
            end
            if (w_latch_left) begin
                r_left_hold <= w_word;
            end
            if (w_commit) begin
                r_data_l <= r_left_hold;
                r_data_r <= w_word;
                r_data   <= w_mix;
            end
        end
    end

    assign o_data         = r_data;
    assign o_data_l       = r_data_l;
    assign o_data_r       = r_data_r;
    assign o_sample_valid = r_valid;
    assign o_err_short    = r_err_short;
    assign o_locked       = r_locked;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Directed bench for i2s_audio_rx: a mono-mix and a left-only instance share
// one I2S stream driven at clk/bclk = 8.
module tb_i2s_audio_rx;

    logic clk = 1'b0;
    logic rst;
    logic bclk;
    logic lrclk;
    logic sdat;

    logic [15:0] mx_data;
    logic [15:0] mx_l;
    logic [15:0] mx_r;
    logic        mx_valid;
    logic        mx_err;
    logic        mx_locked;
    logic [15:0] lo_data;
    logic [15:0] unused_lo_l;
    logic [15:0] unused_lo_r;
    logic        unused_lo_valid;
    logic        unused_lo_err;
    logic        unused_lo_locked;

    i2s_audio_rx #(.SAMPLE_WIDTH(16), .MONO_MIX(1'b1)) u_dut_mix (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_i2s_bclk     (bclk),
        .i_i2s_lrclk    (lrclk),
        .i_i2s_sdat     (sdat),
        .o_data         (mx_data),
        .o_data_l       (mx_l),
        .o_data_r       (mx_r),
        .o_sample_valid (mx_valid),
        .o_err_short    (mx_err),
        .o_locked       (mx_locked)
    );

    i2s_audio_rx #(.SAMPLE_WIDTH(16), .MONO_MIX(1'b0)) u_dut_left (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_i2s_bclk     (bclk),
        .i_i2s_lrclk    (lrclk),
        .i_i2s_sdat     (sdat),
        .o_data         (lo_data),
        .o_data_l       (unused_lo_l),
        .o_data_r       (unused_lo_r),
        .o_sample_valid (unused_lo_valid),
        .o_err_short    (unused_lo_err),
        .o_locked       (unused_lo_locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_err_valid = 0;
    int n_wide = 0;
    int n_hold = 0;
    logic prev_valid = 1'b0;
    logic [15:0] prev_d = '0;
    logic [15:0] prev_l = '0;
    logic [15:0] prev_r = '0;
    logic carry;
    int b_valid;
    int b_err;
    int b_err_valid;

    // Pulse counters, strobe width and output-hold monitor.
    always @(negedge clk) begin
        if (mx_valid) n_valid <= n_valid + 1;
        if (mx_err) n_err <= n_err + 1;
        if (mx_err && mx_valid) n_err_valid <= n_err_valid + 1;
        if (mx_valid && prev_valid) n_wide <= n_wide + 1;
        if (!rst && !mx_valid && ({mx_data, mx_l, mx_r} != {prev_d, prev_l, prev_r}))
            n_hold <= n_hold + 1;
        prev_valid <= mx_valid;
        prev_d     <= mx_data;
        prev_l     <= mx_l;
        prev_r     <= mx_r;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bclk period: data/lrclk change with bclk low, sampled on the rise.
    task automatic send_bit(input logic lr, input logic d, input bit chk_lat);
        time t0;
        bclk  = 1'b0;
        lrclk = lr;
        sdat  = d;
        #40;
        bclk = 1'b1;
        t0   = $time;
        if (chk_lat) begin
            repeat (2) @(posedge clk);
            #1 check("valid_early", {31'd0, mx_valid}, 32'd0);
            @(posedge clk);
            #1 check("valid_latency", {31'd0, mx_valid}, 32'd1);
        end
        #(40 - ($time - t0));
    endtask

    // Word MSB sits one bit after the slot start; bit 0 of a slot carries the
    // previous word's LSB when the word fills its slot.
    task automatic send_slot(input logic lr, input int n_slot, input int n_word,
                             input logic [31:0] word);
        for (int p = 0; p < n_slot; p++) begin
            logic d;
            if (p == 0) d = carry;
            else if (p <= n_word) d = word[n_word-p];
            else d = 1'b0;
            send_bit(lr, d, 1'b0);
        end
        carry = (n_word == n_slot) ? word[0] : 1'b0;
    endtask

    task automatic send_frame(input int n_slot, input int n_word,
                              input logic [31:0] l, input logic [31:0] r);
        send_slot(1'b0, n_slot, n_word, l);
        send_slot(1'b1, n_slot, n_word, r);
    endtask

    task automatic start_stream();
        carry = 1'b0;
        repeat (4) send_bit(1'b1, 1'b0, 1'b0);
        b_valid     = n_valid;
        b_err       = n_err;
        b_err_valid = n_err_valid;
    endtask

    // Right-to-left boundary that commits the last frame, then a few idle bits.
    task automatic send_tail(input bit chk_lat);
        send_bit(1'b0, carry, chk_lat);
        carry = 1'b0;
        repeat (3) send_bit(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        bclk  = 1'b0;
        lrclk = 1'b0;
        sdat  = 1'b0;
        #25;
        rst = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        bclk  = 1'b0;
        lrclk = 1'b0;
        sdat  = 1'b0;
        carry = 1'b0;
        #25;
        check("rst_data", {16'd0, mx_data}, 32'd0);
        check("rst_l", {16'd0, mx_l}, 32'd0);
        check("rst_r", {16'd0, mx_r}, 32'd0);
        check("rst_valid", {31'd0, mx_valid}, 32'd0);
        check("rst_err", {31'd0, mx_err}, 32'd0);
        check("rst_locked", {31'd0, mx_locked}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Basic 32-bit frames with mono mix.
        start_stream();
        send_frame(32, 16, 32'h1234, 32'h8001);
        send_frame(32, 16, 32'h1234, 32'h8001);
        send_tail(1'b1);
        check("basic_l", {16'd0, mx_l}, 32'h1234);
        check("basic_r", {16'd0, mx_r}, 32'h8001);
        check("basic_mix", {16'd0, mx_data}, 32'hC91A);
        check("basic_left_only", {16'd0, lo_data}, 32'h1234);
        check("basic_valid_cnt", n_valid - b_valid, 32'd2);
        check("basic_err_cnt", n_err - b_err, 32'd0);
        check("basic_locked", {31'd0, mx_locked}, 32'd1);

        // Reset in the middle of a left slot, then resume mid-frame.
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        bclk = 1'b0;
        #20;
        rst = 1'b1;
        #1;
        check("midrst_data", {16'd0, mx_data}, 32'd0);
        check("midrst_l", {16'd0, mx_l}, 32'd0);
        check("midrst_r", {16'd0, mx_r}, 32'd0);
        check("midrst_valid", {31'd0, mx_valid}, 32'd0);
        check("midrst_err", {31'd0, mx_err}, 32'd0);
        check("midrst_locked", {31'd0, mx_locked}, 32'd0);
        #19;
        rst = 1'b0;
        @(posedge clk);
        #2;
        b_valid = n_valid;
        repeat (5) send_bit(1'b0, 1'b1, 1'b0);
        repeat (32) send_bit(1'b1, 1'b1, 1'b0);
        carry = 1'b0;
        send_frame(32, 16, 32'h0F0F, 32'h7000);
        check("partial_no_valid", n_valid - b_valid, 32'd0);
        check("relock", {31'd0, mx_locked}, 32'd1);
        send_tail(1'b0);
        check("relock_valid_cnt", n_valid - b_valid, 32'd1);
        check("relock_l", {16'd0, mx_l}, 32'h0F0F);
        check("relock_r", {16'd0, mx_r}, 32'h7000);
        check("relock_mix", {16'd0, mx_data}, 32'h3F87);

        // Left-only output versus mix.
        do_reset();
        start_stream();
        send_frame(32, 16, 32'h7FFF, 32'h8000);
        send_tail(1'b0);
        check("leftonly_data", {16'd0, lo_data}, 32'h7FFF);
        check("leftonly_mix", {16'd0, mx_data}, 32'hFFFF);

        // 24-bit slots truncate to the top 16 bits.
        do_reset();
        start_stream();
        send_frame(24, 24, 32'hABCDEF, 32'h00FF00);
        send_frame(24, 24, 32'hABCDEF, 32'h00FF00);
        send_tail(1'b0);
        check("trunc_l", {16'd0, mx_l}, 32'hABCD);
        check("trunc_r", {16'd0, mx_r}, 32'h00FF);
        check("trunc_mix", {16'd0, mx_data}, 32'hD666);
        check("trunc_err_cnt", n_err - b_err, 32'd0);
        check("trunc_valid_cnt", n_valid - b_valid, 32'd2);

        // 8-bit slots: zero-padded words and an error per slot.
        do_reset();
        start_stream();
        send_frame(8, 8, 32'hA5, 32'h3C);
        send_frame(8, 8, 32'hA5, 32'h3C);
        send_tail(1'b0);
        check("short_l", {16'd0, mx_l}, 32'hA500);
        check("short_r", {16'd0, mx_r}, 32'h3C00);
        check("short_mix", {16'd0, mx_data}, 32'hF080);
        check("short_err_cnt", n_err - b_err, 32'd4);
        check("short_err_with_valid", n_err_valid - b_err_valid, 32'd2);
        check("short_valid_cnt", n_valid - b_valid, 32'd2);

        // Mix rounding toward minus infinity.
        do_reset();
        start_stream();
        send_frame(32, 16, 32'h8000, 32'h8000);
        send_tail(1'b0);
        check("round_min", {16'd0, mx_data}, 32'h8000);
        do_reset();
        start_stream();
        send_frame(32, 16, 32'h0001, 32'hFFFE);
        send_tail(1'b0);
        check("round_neg", {16'd0, mx_data}, 32'hFFFF);

        check("valid_width", n_wide, 32'd0);
        check("output_hold", n_hold, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
